// File: rtl/chess_tick_turn_ctrl.sv
// Turn sequencer for the two-player chess clock: chooses the running side,
// issues increment/restart pulses, declares the winner and counts full moves.
module chess_tick_turn_ctrl #(
  parameter int p_incr_sec = 2,
  parameter int p_moves_w  = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_restart,
  input  logic                 i_stop,
  input  logic                 i_press_a,
  input  logic                 i_press_b,
  input  logic                 i_zero_a,
  input  logic                 i_zero_b,
  output logic                 o_run_a,
  output logic                 o_run_b,
  output logic                 o_add_a,
  output logic                 o_add_b,
  output logic [5:0]           o_add_sec,
  output logic                 o_win_a,
  output logic                 o_win_b,
  output logic                 o_restart,
  output logic [p_moves_w-1:0] o_moves,
  output logic [2:0]           o_dbg_state
);

  typedef enum logic [2:0] {
    s_idle    = 3'd0,
    s_run_a   = 3'd1,
    s_run_b   = 3'd2,
    s_pause_a = 3'd3,
    s_pause_b = 3'd4,
    s_flag_a  = 3'd5,
    s_flag_b  = 3'd6
  } state_t;

  localparam logic incr_on = (p_incr_sec != 0);

  state_t               state, state_nx;
  logic                 add_a_nx, add_b_nx, restart_nx;
  logic [p_moves_w-1:0] moves_nx;

  assign o_add_sec   = 6'(p_incr_sec);
  assign o_dbg_state = state;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state     <= s_idle;
      o_run_a   <= 1'b0;
      o_run_b   <= 1'b0;
      o_add_a   <= 1'b0;
      o_add_b   <= 1'b0;
      o_win_a   <= 1'b0;
      o_win_b   <= 1'b0;
      o_restart <= 1'b0;
      o_moves   <= '0;
    end else begin
      state     <= state_nx;
      o_run_a   <= (state_nx == s_run_a);
      o_run_b   <= (state_nx == s_run_b);
      o_add_a   <= add_a_nx;
      o_add_b   <= add_b_nx;
      o_win_a   <= (state_nx == s_flag_b);
      o_win_b   <= (state_nx == s_flag_a);
      o_restart <= restart_nx;
      o_moves   <= moves_nx;
    end
  end

  // Priority: restart, then the running side's flag, then its press, then stop.
  always_comb begin
    state_nx   = state;
    add_a_nx   = 1'b0;
    add_b_nx   = 1'b0;
    restart_nx = 1'b0;
    moves_nx   = o_moves;
    if (i_restart) begin
      state_nx   = s_idle;
      restart_nx = 1'b1;
      moves_nx   = '0;
    end else begin
      case (state)
        s_idle: begin
          if (i_press_b)      state_nx = s_run_a;
          else if (i_press_a) state_nx = s_run_b;
        end
        s_run_a: begin
          if (i_zero_a) begin
            state_nx = s_flag_a;
          end else if (i_press_a) begin
            state_nx = s_run_b;
            add_a_nx = incr_on;
          end else if (i_stop) begin
            state_nx = s_pause_a;
          end
        end
        s_run_b: begin
          if (i_zero_b) begin
            state_nx = s_flag_b;
          end else if (i_press_b) begin
            state_nx = s_run_a;
            add_b_nx = incr_on;
            if (o_moves != '1) moves_nx = o_moves + 1'b1;
          end else if (i_stop) begin
            state_nx = s_pause_b;
          end
        end
        s_pause_a: if (i_stop) state_nx = s_run_a;
        s_pause_b: if (i_stop) state_nx = s_run_b;
        s_flag_a, s_flag_b: state_nx = state;
        default: state_nx = s_idle;
      endcase
    end
  end

endmodule

// File: tb/tb_chess_tick_turn_ctrl.sv
// Bench for chess_tick_turn_ctrl: two instances (default and no-increment,
// 2-bit move counter) checked every cycle against a game-level model.
module tb_chess_tick_turn_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic restart = 1'b0, stop = 1'b0, pa = 1'b0, pb = 1'b0, za = 1'b0, zb = 1'b0;

  logic       run_a0, run_b0, add_a0, add_b0, win_a0, win_b0, rs0;
  logic [5:0] sec0;
  logic [7:0] moves0;
  logic [2:0] dbg0;
  logic       run_a1, run_b1, add_a1, add_b1, win_a1, win_b1, rs1;
  logic [5:0] sec1;
  logic [1:0] moves1;
  logic [2:0] dbg1;

  int n_cmp = 0;
  int n_bad = 0;
  bit checking = 1'b0;

  always #10 clk = ~clk;

  chess_tick_turn_ctrl #(.p_incr_sec(2), .p_moves_w(8)) dut0 (
    .i_clk(clk), .i_rst(rst), .i_restart(restart), .i_stop(stop),
    .i_press_a(pa), .i_press_b(pb), .i_zero_a(za), .i_zero_b(zb),
    .o_run_a(run_a0), .o_run_b(run_b0), .o_add_a(add_a0), .o_add_b(add_b0),
    .o_add_sec(sec0), .o_win_a(win_a0), .o_win_b(win_b0), .o_restart(rs0),
    .o_moves(moves0), .o_dbg_state(dbg0)
  );

  chess_tick_turn_ctrl #(.p_incr_sec(0), .p_moves_w(2)) dut1 (
    .i_clk(clk), .i_rst(rst), .i_restart(restart), .i_stop(stop),
    .i_press_a(pa), .i_press_b(pb), .i_zero_a(za), .i_zero_b(zb),
    .o_run_a(run_a1), .o_run_b(run_b1), .o_add_a(add_a1), .o_add_b(add_b1),
    .o_add_sec(sec1), .o_win_a(win_a1), .o_win_b(win_b1), .o_restart(rs1),
    .o_moves(moves1), .o_dbg_state(dbg1)
  );

  // Game model: whose clock is live (0 none, 1 A, 2 B), paused, winner
  // (0 none, 1 A, 2 B), full moves, last increment target, restart pulse.
  int m_turn[2], m_pause[2], m_win[2], m_moves[2], m_add[2], m_rp[2];
  int m_incr[2]  = '{2, 0};
  int m_max[2]   = '{255, 3};

  always @(posedge clk or negedge rst) begin
    for (int k = 0; k < 2; k++) begin
      if (!rst) begin
        m_turn[k] = 0; m_pause[k] = 0; m_win[k] = 0;
        m_moves[k] = 0; m_add[k] = 0; m_rp[k] = 0;
      end else begin
        m_add[k] = 0;
        m_rp[k]  = 0;
        if (restart) begin
          m_turn[k] = 0; m_pause[k] = 0; m_win[k] = 0; m_moves[k] = 0; m_rp[k] = 1;
        end else if (m_win[k] != 0) begin
          // game over
        end else if (m_turn[k] == 0) begin
          if (pb)      m_turn[k] = 1;
          else if (pa) m_turn[k] = 2;
        end else if (m_pause[k] != 0) begin
          if (stop) m_pause[k] = 0;
        end else if ((m_turn[k] == 1) ? za : zb) begin
          m_win[k]  = 3 - m_turn[k];
          m_turn[k] = 0;
        end else if ((m_turn[k] == 1) ? pa : pb) begin
          if (m_incr[k] != 0) m_add[k] = m_turn[k];
          if (m_turn[k] == 2 && m_moves[k] < m_max[k]) m_moves[k] = m_moves[k] + 1;
          m_turn[k] = 3 - m_turn[k];
        end else if (stop) begin
          m_pause[k] = 1;
        end
      end
    end
  end

  function automatic logic [14:0] exp_vec(int k);
    logic live;
    live = (m_win[k] == 0) && (m_pause[k] == 0);
    return {live && m_turn[k] == 1, live && m_turn[k] == 2,
            m_add[k] == 1, m_add[k] == 2, m_win[k] == 1, m_win[k] == 2,
            m_rp[k] != 0, 8'(m_moves[k])};
  endfunction

  always @(negedge clk) begin
    logic [14:0] act0, act1, e0, e1;
    if (checking) begin
      act0 = {run_a0, run_b0, add_a0, add_b0, win_a0, win_b0, rs0, moves0};
      act1 = {run_a1, run_b1, add_a1, add_b1, win_a1, win_b1, rs1, 6'd0, moves1};
      e0 = exp_vec(0);
      e1 = exp_vec(1);
      n_cmp += 2;
      if (act0 !== e0) begin
        n_bad++;
        $display("FAIL cycle_dut0 t=%0t actual=%b required=%b", $time, act0, e0);
      end
      if (act1 !== e1) begin
        n_bad++;
        $display("FAIL cycle_dut1 t=%0t actual=%b required=%b", $time, act1, e1);
      end
    end
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic cycle(input logic r, input logic s, input logic a, input logic b,
                       input logic x, input logic y);
    @(negedge clk);
    restart = r; stop = s; pa = a; pb = b; za = x; zb = y;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #35;
    rst = 1'b1;
    checking = 1'b1;
    check("sec0", 8'(sec0), 8'd2);
    check("sec1", 8'(sec1), 8'd0);
    check("rst_moves", moves0, 8'd0);
    check("rst_run", {6'd0, run_a0, run_b0}, 8'd0);

    cycle(0, 0, 0, 1, 0, 0);
    check("t1_run", {4'd0, run_a0, run_b0, add_a0, add_b0}, 8'b1000);
    cycle(0, 0, 1, 0, 0, 0);
    check("t2_turn_b", {4'd0, run_a0, run_b0, add_a0, add_b0}, 8'b0110);
    check("t2_moves", moves0, 8'd0);
    cycle(0, 0, 0, 0, 0, 0);
    check("t2_add_gone", {7'd0, add_a0}, 8'd0);
    cycle(0, 0, 0, 1, 0, 0);
    check("t2_turn_a", {4'd0, run_a0, run_b0, add_a0, add_b0}, 8'b1001);
    check("t2_moves1", moves0, 8'd1);

    cycle(0, 0, 1, 0, 1, 0);
    check("t3_flag", {4'd0, win_a0, win_b0, add_a0, run_b0}, 8'b0100);
    cycle(0, 1, 1, 1, 0, 0);
    check("t3_terminal", {5'd0, win_b0, run_a0, run_b0}, 8'b100);

    cycle(1, 0, 1, 0, 0, 0);
    check("t5_restart", {6'd0, rs0, win_b0}, 8'b10);
    check("t5_moves", moves0, 8'd0);
    cycle(0, 0, 0, 0, 0, 0);
    check("t5_pulse_once", {7'd0, rs0}, 8'd0);

    cycle(0, 0, 1, 0, 0, 0);
    check("t4_run_b", {6'd0, run_a0, run_b0}, 8'b01);
    cycle(0, 1, 0, 0, 0, 0);
    check("t4_paused", {6'd0, run_a0, run_b0}, 8'b00);
    cycle(0, 0, 0, 1, 0, 1);
    check("t4_press_ignored", {5'd0, run_b0, add_b0, win_a0}, 8'd0);
    cycle(0, 1, 0, 0, 0, 0);
    check("t4_resume", {6'd0, run_a0, run_b0}, 8'b01);

    cycle(1, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 5; i++) begin
      cycle(0, 0, 1, 0, 0, 0);
      cycle(0, 0, 0, 1, 0, 0);
    end
    check("t6_sat", {6'd0, moves1}, 8'd3);
    check("t6_moves", moves0, 8'd5);
    check("t6_no_add", {6'd0, add_a1, add_b1}, 8'd0);

    // Stale zero flag of the waiting side must not end the game.
    cycle(0, 0, 0, 0, 0, 1);
    check("stale_zero", {6'd0, win_a0, run_a0}, 8'b01);

    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("async_rst", {5'd0, run_a0, rs0, win_a0}, 8'd0);
    check("async_rst_moves", moves0, 8'd0);
    @(negedge clk);
    #1 rst = 1'b1;

    for (int i = 0; i < 3000; i++) begin
      cycle($urandom_range(0, 79) == 0, $urandom_range(0, 7) == 0,
            $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
            $urandom_range(0, 59) == 0, $urandom_range(0, 59) == 0);
    end
    cycle(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    #1;
    checking = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
